// File: rtl/i2c_pkg.sv
// Shared definitions for the two-wire write master and the bus monitors.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_ACK1,
        ST_DATA,
        ST_ACK2,
        ST_STOP
    } state_t;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam logic RW_WRITE = 1'b0;

    typedef struct packed {
        logic scl;
        logic sda_o;
        logic sda_oe;
    } bus_drv_t;

    // Line levels for a given state/quarter; bitv is the bit being shifted out.
    function automatic bus_drv_t bus_drive(state_t st, logic [1:0] ph, logic bitv);
        bus_drv_t d;
        d.scl    = 1'b1;
        d.sda_o  = 1'b1;
        d.sda_oe = 1'b0;
        case (st)
            ST_START: begin
                d.sda_oe = 1'b1;
                d.scl    = (ph != Q3);
                d.sda_o  = (ph == Q0) || (ph == Q1);
            end
            ST_ADDR, ST_DATA: begin
                d.sda_oe = 1'b1;
                d.scl    = (ph == Q2) || (ph == Q3);
                d.sda_o  = bitv;
            end
            ST_ACK1, ST_ACK2: begin
                d.scl    = (ph == Q2) || (ph == Q3);
            end
            ST_STOP: begin
                d.sda_oe = 1'b1;
                d.scl    = (ph != Q0);
                d.sda_o  = (ph == Q2) || (ph == Q3);
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/i2c_write_master_if.sv
// Request side and bus side of the write master.
interface i2c_write_master_if;
    logic       start;
    logic [6:0] addr;
    logic [7:0] data;
    logic       sda_i;
    logic       scl;
    logic       sda_o;
    logic       sda_oe;
    logic       busy;
    logic       done;
    logic       ack_err;

    modport master (
        input  start, addr, data, sda_i,
        output scl, sda_o, sda_oe, busy, done, ack_err
    );

    modport slave (
        output start, addr, data, sda_i,
        input  scl, sda_o, sda_oe, busy, done, ack_err
    );
endinterface

// File: rtl/i2c_quarter_tick.sv
// Divides clk into quarter-SCL periods and tracks the quarter phase.
module i2c_quarter_tick
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    output logic       tick,
    output logic [1:0] phase
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

    logic [DW-1:0] div;

    // tick marks the last clk of the current quarter
    assign tick = (div == DIV_MAX);

    // divider and phase; clr holds both at the start of q0
    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            div   <= '0;
            phase <= Q0;
        end else if (tick) begin
            div   <= '0;
            phase <= phase + 2'd1;
        end else begin
            div   <= div + 1'b1;
        end
    end
endmodule

// File: rtl/i2c_write_master.sv
// Two-wire bus master: START, addr+W, ACK, data, ACK, STOP.
module i2c_write_master
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    i2c_write_master_if.master   bus
);
    state_t     state, state_n;
    logic [7:0] shreg, shreg_n, data_lat;
    logic [2:0] bitcnt, bitcnt_n;
    logic [1:0] phase, phase_n;
    logic       tick, tick_clr, qend, accept, ack_smp, nack, done_n;
    bus_drv_t   drv_n;

    // divider idles cleared so an accepted start begins exactly at q0
    assign tick_clr = (state == ST_IDLE);

    i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (tick_clr),
        .tick  (tick),
        .phase (phase)
    );

    assign qend    = tick && (phase == Q3);
    assign accept  = (state == ST_IDLE) && bus.start;
    assign ack_smp = tick && (phase == Q2) && ((state == ST_ACK1) || (state == ST_ACK2));

    // next state, shift data and bit count; outputs are decoded from next values
    always_comb begin
        state_n  = state;
        shreg_n  = shreg;
        bitcnt_n = bitcnt;
        done_n   = 1'b0;
        phase_n  = tick_clr ? Q0 : (tick ? phase + 2'd1 : phase);
        case (state)
            ST_IDLE: if (bus.start) begin
                state_n = ST_START;
                shreg_n = {bus.addr, RW_WRITE};
            end
            ST_START: if (qend) state_n = ST_ADDR;
            ST_ADDR, ST_DATA: if (qend) begin
                shreg_n  = {shreg[6:0], 1'b0};
                bitcnt_n = bitcnt + 3'd1;
                if (bitcnt == 3'd7) state_n = (state == ST_ADDR) ? ST_ACK1 : ST_ACK2;
            end
            ST_ACK1: if (qend) begin
                if (nack) begin
                    state_n = ST_STOP;
                end else begin
                    state_n = ST_DATA;
                    shreg_n = data_lat;
                end
            end
            ST_ACK2: if (qend) state_n = ST_STOP;
            ST_STOP: if (qend) begin
                state_n = ST_IDLE;
                done_n  = 1'b1;
            end
            default: state_n = ST_IDLE;
        endcase
        drv_n = bus_drive(state_n, phase_n, shreg_n[7]);
    end

    // state register and registered bus/status outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            shreg       <= '0;
            bitcnt      <= '0;
            data_lat    <= '0;
            nack        <= 1'b0;
            bus.scl     <= 1'b1;
            bus.sda_o   <= 1'b1;
            bus.sda_oe  <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.ack_err <= 1'b0;
        end else begin
            state       <= state_n;
            shreg       <= shreg_n;
            bitcnt      <= bitcnt_n;
            bus.scl     <= drv_n.scl;
            bus.sda_o   <= drv_n.sda_o;
            bus.sda_oe  <= drv_n.sda_oe;
            bus.busy    <= (state_n != ST_IDLE);
            bus.done    <= done_n;
            if (accept) data_lat <= bus.data;
            if (ack_smp) nack <= bus.sda_i;
            if (accept)
                bus.ack_err <= 1'b0;
            else if (ack_smp && bus.sda_i)
                bus.ack_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_i2c_write_master.sv
// Bench for i2c_write_master: two instances (CLK_DIV 4 and 1) with a bus slave/monitor.
module tb_i2c_write_master;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   nvec = 0;
    int   nerr = 0;

    logic [1:0]      start_r = '0;
    logic [1:0][6:0] addr_r  = '0;
    logic [1:0][7:0] data_r  = '0;
    logic ack_a [2];
    logic ack_d [2];

    logic scl_w [2], so_w [2], oe_w [2], busy_w [2], done_w [2], err_w [2], sda_w [2];
    logic pull [2];

    int          cnt [2], nbits [2], nstart [2], nstop [2], ndone [2], done_cyc [2];
    logic [31:0] bits [2];
    logic        pscl [2], psda [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : u
        i2c_write_master_if bus ();
        assign bus.start = start_r[g];
        assign bus.addr  = addr_r[g];
        assign bus.data  = data_r[g];
        assign sda_w[g]  = bus.sda_oe ? bus.sda_o : !pull[g];
        assign bus.sda_i = sda_w[g];
        assign scl_w[g]  = bus.scl;
        assign so_w[g]   = bus.sda_o;
        assign oe_w[g]   = bus.sda_oe;
        assign busy_w[g] = bus.busy;
        assign done_w[g] = bus.done;
        assign err_w[g]  = bus.ack_err;
        i2c_write_master #(.CLK_DIV(g == 0 ? 4 : 1)) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus.master)
        );
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // slave + monitor: START/STOP events, sda at scl rises, ACK pulls, done pulses
    initial begin
        for (int g = 0; g < 2; g++) begin
            cnt[g] = 99; nbits[g] = 0; nstart[g] = 0; nstop[g] = 0; ndone[g] = 0;
            done_cyc[g] = 0; bits[g] = '0; pull[g] = 1'b0; pscl[g] = 1'b1; psda[g] = 1'b1;
        end
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                if (!reset) begin
                    cnt[g] = 99; pull[g] = 1'b0; pscl[g] = 1'b1; psda[g] = 1'b1;
                end else begin
                    if (pscl[g] && scl_w[g] && psda[g] && !sda_w[g]) begin
                        nstart[g]++; cnt[g] = 0; bits[g] = '0; nbits[g] = 0;
                    end
                    if (pscl[g] && scl_w[g] && !psda[g] && sda_w[g]) nstop[g]++;
                    if (!pscl[g] && scl_w[g]) begin
                        bits[g] = {bits[g][30:0], sda_w[g]}; nbits[g]++;
                    end
                    if (pscl[g] && !scl_w[g]) cnt[g]++;
                    pull[g] = (cnt[g] == 9 && ack_a[g]) || (cnt[g] == 18 && ack_d[g]);
                    if (done_w[g]) begin ndone[g]++; done_cyc[g] = cyc; end
                    pscl[g] = scl_w[g];
                    psda[g] = sda_w[g];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int dv(input int g);
        return (g == 0) ? 4 : 1;
    endfunction

    // expected sda at each scl rise from START to STOP
    function automatic logic [31:0] exp_bits(input logic [6:0] a, input logic [7:0] d,
                                             input logic acka, input logic ackd, output int n);
        logic [31:0] v;
        v = '0; n = 0;
        for (int i = 6; i >= 0; i--) begin v = {v[30:0], a[i]}; n++; end
        v = {v[30:0], 1'b0}; n++;
        v = {v[30:0], ~acka}; n++;
        if (acka) begin
            for (int i = 7; i >= 0; i--) begin v = {v[30:0], d[i]}; n++; end
            v = {v[30:0], ~ackd}; n++;
        end
        v = {v[30:0], 1'b0}; n++;
        return v;
    endfunction

    task automatic issue(input int g, input logic [6:0] a, input logic [7:0] d, output int t);
        @(posedge clk); #1;
        start_r[g] = 1'b1; addr_r[g] = a; data_r[g] = d; t = cyc;
        @(posedge clk); #1;
        start_r[g] = 1'b0; addr_r[g] = 7'($urandom); data_r[g] = 8'($urandom);
        check("busy_after_accept", 32'(busy_w[g]), 32'd1);
    endtask

    task automatic finish_txn(input int g, input int t, input logic [6:0] a, input logic [7:0] d,
                              input logic acka, input logic ackd, input int n0, input int s0, input int p0);
        int q, en;
        logic [31:0] ev;
        q = acka ? 80 : 44;
        for (int i = 0; i < q * dv(g) + 20; i++) begin
            @(negedge clk); #1;
            if (ndone[g] != n0) break;
        end
        check("done_seen", 32'(ndone[g]), 32'(n0 + 1));
        check("done_cycle", 32'(done_cyc[g]), 32'(t + 1 + q * dv(g)));
        check("ack_err", 32'(err_w[g]), 32'(!acka || !ackd));
        ev = exp_bits(a, d, acka, ackd, en);
        check("bit_count", 32'(nbits[g]), 32'(en));
        check("bit_stream", bits[g], ev);
        check("start_stop_events", 32'((nstart[g] - s0) * 16 + (nstop[g] - p0)), 32'd17);
        repeat (4) @(posedge clk);
        #1;
        check("idle_after", 32'({busy_w[g], oe_w[g], scl_w[g]}), 32'd1);
        check("single_done", 32'(ndone[g] - n0), 32'd1);
    endtask

    task automatic txn(input int g, input logic [6:0] a, input logic [7:0] d,
                       input logic acka, input logic ackd);
        int t, n0, s0, p0;
        ack_a[g] = acka; ack_d[g] = ackd;
        n0 = ndone[g]; s0 = nstart[g]; p0 = nstop[g];
        issue(g, a, d, t);
        finish_txn(g, t, a, d, acka, ackd, n0, s0, p0);
    endtask

    initial begin
        int t, t2, n0, s0, p0, en;
        logic [6:0] a2;
        logic [7:0] d2;
        for (int g = 0; g < 2; g++) begin ack_a[g] = 1'b1; ack_d[g] = 1'b1; end

        // reset held for 2 clks
        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++)
            check("reset_state", 32'({scl_w[g], so_w[g], oe_w[g], busy_w[g], done_w[g], err_w[g]}), 32'h30);
        reset = 1'b1;

        // full ACKed write, CLK_DIV=4
        txn(0, 7'h2A, 8'hC5, 1'b1, 1'b1);
        // address NACK
        txn(0, 7'h2A, 8'hC5, 1'b0, 1'b1);
        // ack_err cleared by the next accepted start
        txn(0, 7'h15, 8'h3C, 1'b1, 1'b1);

        // start with addr 7F during busy is ignored
        ack_a[0] = 1'b1; ack_d[0] = 1'b1;
        n0 = ndone[0]; s0 = nstart[0]; p0 = nstop[0];
        issue(0, 7'h2A, 8'hC5, t);
        repeat (49) @(posedge clk);
        #1;
        start_r[0] = 1'b1; addr_r[0] = 7'h7F;
        @(posedge clk); #1;
        start_r[0] = 1'b0;
        check("busy_during_ignored_start", 32'(busy_w[0]), 32'd1);
        finish_txn(0, t, 7'h2A, 8'hC5, 1'b1, 1'b1, n0, s0, p0);

        // reset for 1 clk in the middle of the data byte
        n0 = ndone[0];
        issue(0, 7'h51, 8'hA7, t);
        repeat (200) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("mid_reset_state", 32'({scl_w[0], oe_w[0], busy_w[0], done_w[0], err_w[0]}), 32'h10);
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("mid_reset_no_done", 32'(ndone[0] - n0), 32'd0);
        txn(0, 7'h51, 8'hA7, 1'b1, 1'b1);

        // CLK_DIV=1, addr 00 data FF, then a start on the done cycle
        ack_a[1] = 1'b1; ack_d[1] = 1'b1;
        n0 = ndone[1]; s0 = nstart[1]; p0 = nstop[1];
        issue(1, 7'h00, 8'hFF, t);
        repeat (80) @(posedge clk);
        #1;
        check("div1_done_at_T81", 32'(done_w[1]), 32'd1);
        void'(exp_bits(7'h00, 8'hFF, 1'b1, 1'b1, en));
        check("div1_bits", bits[1], exp_bits(7'h00, 8'hFF, 1'b1, 1'b1, en));
        check("div1_events", 32'((nstart[1] - s0) * 16 + (nstop[1] - p0)), 32'd17);
        a2 = 7'($urandom); d2 = 8'($urandom);
        start_r[1] = 1'b1; addr_r[1] = a2; data_r[1] = d2; t2 = cyc;
        @(posedge clk); #1;
        start_r[1] = 1'b0;
        check("accept_on_done", 32'({busy_w[1], done_w[1]}), 32'd2);
        finish_txn(1, t2, a2, d2, 1'b1, 1'b1, n0 + 1, nstart[1], nstop[1]);

        // randomized transactions on both instances
        for (int k = 0; k < 8; k++)
            txn(k % 2, 7'($urandom), 8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
